// File: rtl/snooper_command_sequencer_if.sv
// Signal bundle between the command sequencer and its usart_rx / usart_tx / snooper neighbours.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface snooper_command_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_error;
  logic       rx_acknowledge;
  logic       record_start;
  logic       record_end;
  logic       record_trigger;
  logic       dump_start;
  logic       dump_end;
  logic       snoop_valid;
  logic [7:0] snoop_data;
  logic       snoop_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       error;

  modport master (
    input  rx_data, rx_available, rx_error, record_end, dump_end,
           snoop_valid, snoop_data, tx_ready,
    output rx_acknowledge, record_start, record_trigger, dump_start,
           snoop_ready, tx_valid, tx_data, busy, error
  );

  modport slave (
    output rx_data, rx_available, rx_error, record_end, dump_end,
           snoop_valid, snoop_data, tx_ready,
    input  rx_acknowledge, record_start, record_trigger, dump_start,
           snoop_ready, tx_valid, tx_data, busy, error
  );
endinterface

// File: rtl/snooper_command_sequencer.sv
// Serial command controller for the bus snooper: decodes one-byte ASCII commands, sequences
// arm / trigger / dump, and arbitrates the single tx byte stream between dump data and replies.
module snooper_command_sequencer #(
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter logic [7:0]  ACK_CHAR     = 8'h2B,
  parameter logic [7:0]  NAK_CHAR     = 8'h3F
) (
  input logic                         comm_clock,
  input logic                         reset,
  snooper_command_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ARMED, DUMP, REPLY} state_t;

  localparam logic [7:0] CMD_ARM        = 8'h61;
  localparam logic [7:0] CMD_CLEAR      = 8'h63;
  localparam logic [7:0] CMD_DUMP       = 8'h64;
  localparam logic [7:0] CMD_STATUS     = 8'h73;
  localparam logic [7:0] CMD_TRIGGER    = 8'h74;
  localparam logic [7:0] STATUS_CHAR    = 8'h53;
  localparam logic [7:0] CAPTURED_CHAR  = 8'h21;
  localparam logic [7:0] DUMP_DONE_CHAR = 8'h0A;

  state_t                  state_q, state_d, ret_q, ret_d;
  logic [7:0]              reply0_q, reply0_d, reply1_q, reply1_d;
  logic                    two_q, two_d;   // reply holds two bytes
  logic                    idx_q, idx_d;   // reply byte currently offered
  logic                    captured_q, captured_d;
  logic                    record_start_q, record_start_d;
  logic                    error_q, error_d;
  logic [TIMEOUT_BITS-1:0] stall_q, stall_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ret_q          <= IDLE;
      reply0_q       <= '0;
      reply1_q       <= '0;
      two_q          <= 1'b0;
      idx_q          <= 1'b0;
      captured_q     <= 1'b0;
      record_start_q <= 1'b0;
      error_q        <= 1'b0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      reply0_q       <= reply0_d;
      reply1_q       <= reply1_d;
      two_q          <= two_d;
      idx_q          <= idx_d;
      captured_q     <= captured_d;
      record_start_q <= record_start_d;
      error_q        <= error_d;
      stall_q        <= stall_d;
    end
  end

  assign bus.record_start = record_start_q;
  assign bus.error        = error_q;
  assign bus.busy         = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d            = state_q;
    ret_d              = ret_q;
    reply0_d           = reply0_q;
    reply1_d           = reply1_q;
    two_d              = two_q;
    idx_d              = idx_q;
    captured_d         = captured_q;
    record_start_d     = record_start_q;
    error_d            = error_q;
    stall_d            = '0;
    bus.rx_acknowledge = 1'b0;
    bus.record_trigger = 1'b0;
    bus.dump_start     = 1'b0;
    bus.snoop_ready    = 1'b0;
    bus.tx_valid       = 1'b0;
    bus.tx_data        = '0;

    case (state_q)
      IDLE, ARMED: begin
        if (bus.rx_available) begin
          // Default outcome of any accepted command: single NAK, return to where we were.
          bus.rx_acknowledge = 1'b1;
          state_d            = REPLY;
          ret_d              = state_q;
          reply0_d           = NAK_CHAR;
          two_d              = 1'b0;
          idx_d              = 1'b0;
          case (bus.rx_data)
            CMD_STATUS: begin
              reply0_d = STATUS_CHAR;
              reply1_d = {4'h3, record_start_q, captured_q, error_q, 1'b0};
              two_d    = 1'b1;
            end
            CMD_CLEAR: begin
              reply0_d = ACK_CHAR;
              ret_d    = IDLE;
              if (state_q == IDLE) begin
                error_d    = 1'b0;
                captured_d = 1'b0;
              end else begin
                record_start_d = 1'b0;
              end
            end
            CMD_ARM: begin
              if (state_q == IDLE) begin
                record_start_d = 1'b1;
                captured_d     = 1'b0;
                reply0_d       = ACK_CHAR;
                ret_d          = ARMED;
              end
            end
            CMD_DUMP: begin
              if (state_q == IDLE && captured_q) begin
                bus.dump_start = 1'b1;
                state_d        = DUMP;
              end
            end
            CMD_TRIGGER: begin
              if (state_q == ARMED) begin
                bus.record_trigger = 1'b1;
                reply0_d           = ACK_CHAR;
              end
            end
            default: ;
          endcase
        end else if (state_q == ARMED && bus.record_end) begin
          record_start_d = 1'b0;
          captured_d     = 1'b1;
          reply0_d       = CAPTURED_CHAR;
          two_d          = 1'b0;
          idx_d          = 1'b0;
          ret_d          = IDLE;
          state_d        = REPLY;
        end
      end

      DUMP: begin
        // Snooper bytes go straight through to usart_tx; the stall counter guards a hung consumer.
        bus.tx_valid    = bus.snoop_valid;
        bus.tx_data     = bus.snoop_data;
        bus.snoop_ready = bus.tx_ready;
        two_d           = 1'b0;
        idx_d           = 1'b0;
        ret_d           = IDLE;
        if (bus.dump_end) begin
          reply0_d = DUMP_DONE_CHAR;
          state_d  = REPLY;
        end else if (bus.snoop_valid && bus.tx_ready) begin
          stall_d = '0;
        end else if (&stall_q) begin
          error_d  = 1'b1;
          reply0_d = NAK_CHAR;
          state_d  = REPLY;
        end else begin
          stall_d = stall_q + TIMEOUT_BITS'(1);
        end
      end

      REPLY: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = idx_q ? reply1_q : reply0_q;
        if (bus.tx_ready) begin
          if (idx_q == two_q) begin
            idx_d   = 1'b0;
            state_d = ret_q;
          end else begin
            idx_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A framing error is sticky and outranks a same-cycle clear.
    if (bus.rx_error) error_d = 1'b1;
  end
endmodule
